ascii_number_receiver: RTL
==========================

Name: ascii_number_receiver

Overview:
- Receive-side counterpart of the printer/ROM path. It parses a framed, signed decimal ASCII number arriving byte-by-byte from the UART receiver (`rx_data`/`new_rx_data`) into a two's-complement binary word.
- It presents the word to downstream logic with a valid/ack handshake.
- It replaces the ad-hoc raw-byte capture in the console command path. Frame format is: START_CHAR, optional '-', one or more digits, then a terminator.

Parameters:
- WIDTH, 32, width of the signed result.
- START_CHAR, 8'h68 ("h"), byte that opens a frame.
- TIMEOUT_CYCLES, 0, max clk cycles between bytes inside a frame; 0 disables the timeout.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-low (asserting rst=0 resets immediately, independent of clk).
- rx_data  input  8  received byte; valid only when new_rx_data=1.
- new_rx_data  input  1  one-cycle strobe, one byte per strobe.
- value  output  WIDTH  parsed signed result; stable while value_valid=1.
- value_valid  output  1  result available; held until value_ack.
- value_ack  input  1  consumer accepts value; sampled only while value_valid=1.
- err  output  1  one-cycle error pulse.
- err_code  output  3  cause, valid when err=1: 1 BAD_CHAR, 2 OVERFLOW, 3 EMPTY, 4 OVERRUN, 5 TIMEOUT.
- busy  output  1  high in SIGN, DIGITS or HOLD.

Behaviour:
- Reset values: value=0, value_valid=0, err=0, err_code=0, busy=0. FSM goes to IDLE; accumulator, sign and timeout counter are cleared. A reset mid-frame discards the partial frame with no error.
- All outputs are registered. A byte strobed in cycle N affects outputs from cycle N+1.
- Digits are bytes 0x30-0x39. Terminators are 0x0D, 0x0A and 0x20.

FSM states:
- IDLE: only new_rx_data with rx_data==START_CHAR is acted on. It clears the accumulator and neg flag, then goes to SIGN. All other bytes are silently ignored.
- SIGN:
  - '-' sets neg=1 and goes to DIGITS.
  - A digit sets acc=d, ndig=1 and goes to DIGITS.
  - START_CHAR stays in SIGN, cleared.
  - A terminator raises EMPTY and goes to IDLE.
  - Any other byte raises BAD_CHAR and goes to IDLE.
- DIGITS:
  - A digit computes acc_next=acc*10+d in WIDTH+4 bits. If acc_next exceeds LIMIT, raise OVERFLOW and go to IDLE. Otherwise acc=acc_next and ndig++ (saturating).
  - LIMIT is 2^(WIDTH-1)-1 when neg=0 and 2^(WIDTH-1) when neg=1.
  - Leading zeros are unlimited; only the value is range-checked.
  - A terminator with ndig=0 raises EMPTY. With ndig>0 it loads value = neg ? -acc : acc, sets value_valid=1 and goes to HOLD.
  - START_CHAR restarts the frame: cleared, go to SIGN, no error.
  - Any other byte (including a second '-') raises BAD_CHAR and goes to IDLE.
- HOLD:
  - value_valid=1 and value is frozen.
  - value_ack=1 clears value_valid next cycle and goes to IDLE.
  - Any new_rx_data in HOLD is dropped and raises OVERRUN. This includes the ack cycle: the byte is still dropped, OVERRUN still pulses, and ack still completes.
- Timeout: applies only when TIMEOUT_CYCLES>0, in SIGN and DIGITS. The counter resets on every strobe. When the count reaches TIMEOUT_CYCLES with no strobe, raise TIMEOUT and go to IDLE.
- Error pulses: err=1 for exactly one cycle with err_code, then err=0. err_code holds its last value between pulses. Any error discards the partial frame.
- value_ack outside HOLD is ignored.

Test Plan:
- "h","1","2","3",0x0D (bytes spaced 3 cycles) -> value_valid rises the cycle after the CR strobe with value=123. It stays high with value=123 for 20 cycles without ack. Ack -> value_valid=0 next cycle, busy=0.
- "h-2147483648",0x0A -> value=32'h80000000.
- "h2147483648",0x20 -> err pulse, err_code=2, no value_valid, FSM in IDLE.
- "h-",0x0D -> err_code=3.
- "h12a4",0x0D -> err_code=1 at 'a'. The following "4" and CR are ignored (no valid, no err).
- "h12h34",0x0D -> value=34, no err. "h000000000000057",0x0D -> value=57.
- In HOLD with value=5, strobe "9" -> err_code=4 and value stays 5. Strobe a byte in the same cycle as ack -> OVERRUN pulse and value_valid=0 next cycle.
- Async reset asserted mid-DIGITS between clock edges -> all outputs 0 immediately. After release, "h7",0x0D -> value=7.
- With TIMEOUT_CYCLES=16: "h1" then idle 16 cycles -> err_code=5. A subsequent CR is ignored.

Source files
------------

// File: rtl/ascii_number_receiver.sv
// ascii_number_receiver
// Parses a framed, signed decimal ASCII number arriving one byte per strobe
// (START_CHAR, optional '-', digits, terminator) into a two's-complement word.
//
// Result handshake: value/value_valid rise together the cycle after the
// terminator strobe and stay frozen until value_ack is seen high while
// value_valid=1. value_valid drops the following cycle. value_ack is ignored
// at all other times. No other byte is parsed while a result is being held.
// Each such byte is dropped and reported as OVERRUN.
module ascii_number_receiver #(
  parameter int         WIDTH          = 32,
  parameter logic [7:0] START_CHAR     = 8'h68,
  parameter int         TIMEOUT_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             new_rx_data,
  output logic [WIDTH-1:0] value,
  output logic             value_valid,
  input  logic             value_ack,
  output logic             err,
  output logic [2:0]       err_code,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SIGN   = 2'd1,
    S_DIGITS = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  localparam logic [2:0] E_BAD_CHAR = 3'd1;
  localparam logic [2:0] E_OVERFLOW = 3'd2;
  localparam logic [2:0] E_EMPTY    = 3'd3;
  localparam logic [2:0] E_OVERRUN  = 3'd4;
  localparam logic [2:0] E_TIMEOUT  = 3'd5;

  // Accumulator arithmetic is 4 bits wider so acc*10+d can never wrap.
  localparam int AW = WIDTH + 4;
  localparam logic [AW-1:0] LIMIT_POS = {{5{1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [AW-1:0] LIMIT_NEG = {{4{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

  // Timeout counter only needs to hold 0..TIMEOUT_CYCLES-1.
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic             neg;
  logic [3:0]       ndig;
  logic [TW-1:0]    tcnt;

  logic             is_digit;
  logic             is_term;
  logic             is_start;
  logic             is_minus;
  logic [AW-1:0]    acc_ext;
  logic [AW-1:0]    acc_next;
  logic             acc_ovf;
  logic [WIDTH-1:0] acc_neg;
  logic             to_fire;

  // Byte classification and the next accumulator value for a digit byte.
  always_comb begin
    is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    is_term  = (rx_data == 8'h0D) || (rx_data == 8'h0A) || (rx_data == 8'h20);
    is_start = (rx_data == START_CHAR);
    is_minus = (rx_data == 8'h2D);
    acc_ext  = {4'b0000, acc};
    acc_next = (acc_ext << 3) + (acc_ext << 1) + {{(AW-4){1'b0}}, rx_data[3:0]};
    acc_ovf  = acc_next > (neg ? LIMIT_NEG : LIMIT_POS);
    acc_neg  = ~acc + WIDTH'(1);
    to_fire  = (TIMEOUT_CYCLES > 0) && (tcnt == TO_LAST);
  end

  assign state_dbg = state;

  // Parser FSM: all outputs are registered here, err is a one-cycle pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      acc         <= '0;
      neg         <= 1'b0;
      ndig        <= 4'd0;
      tcnt        <= '0;
      value       <= '0;
      value_valid <= 1'b0;
      err         <= 1'b0;
      err_code    <= 3'd0;
      busy        <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          tcnt <= '0;
          if (new_rx_data && is_start) begin
            acc   <= '0;
            neg   <= 1'b0;
            ndig  <= 4'd0;
            state <= S_SIGN;
            busy  <= 1'b1;
          end
        end

        S_SIGN, S_DIGITS: begin
          if (new_rx_data) begin
            tcnt <= '0;
            if (is_start) begin
              // A fresh start byte restarts the frame without complaint.
              acc   <= '0;
              neg   <= 1'b0;
              ndig  <= 4'd0;
              state <= S_SIGN;
            end else if (is_minus && state == S_SIGN) begin
              neg   <= 1'b1;
              state <= S_DIGITS;
            end else if (is_digit) begin
              if (acc_ovf) begin
                err      <= 1'b1;
                err_code <= E_OVERFLOW;
                state    <= S_IDLE;
                busy     <= 1'b0;
              end else begin
                acc   <= acc_next[WIDTH-1:0];
                state <= S_DIGITS;
                if (ndig != 4'hF) ndig <= ndig + 4'd1;
              end
            end else if (is_term) begin
              if (ndig == 4'd0) begin
                err      <= 1'b1;
                err_code <= E_EMPTY;
                state    <= S_IDLE;
                busy     <= 1'b0;
              end else begin
                value       <= neg ? acc_neg : acc;
                value_valid <= 1'b1;
                state       <= S_HOLD;
              end
            end else begin
              err      <= 1'b1;
              err_code <= E_BAD_CHAR;
              state    <= S_IDLE;
              busy     <= 1'b0;
            end
          end else if (to_fire) begin
            tcnt     <= '0;
            err      <= 1'b1;
            err_code <= E_TIMEOUT;
            state    <= S_IDLE;
            busy     <= 1'b0;
          end else if (TIMEOUT_CYCLES > 0) begin
            tcnt <= tcnt + TW'(1);
          end
        end

        S_HOLD: begin
          // Bytes are dropped while holding; the ack still completes.
          if (new_rx_data) begin
            err      <= 1'b1;
            err_code <= E_OVERRUN;
          end
          if (value_ack) begin
            value_valid <= 1'b0;
            state       <= S_IDLE;
            busy        <= 1'b0;
          end
        end

        default: begin
          state       <= S_IDLE;
          value_valid <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule
